// File: rtl/ps2_pkg.sv
// Shared constants and frame FSM encoding for the PS/2 mouse receiver.
package ps2_pkg;

    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam int unsigned PS2_DATA_BITS  = 8;
    localparam int unsigned STAT_ALIGN_BIT = 3;
    localparam int unsigned BIT_CNT_W      = 3;
    localparam int unsigned PKT_IDX_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

endpackage

// File: rtl/ps2_mouse_rx_byte_rx.sv
// PS/2 line synchroniser, falling-edge detect and 11-bit frame deserialiser.
module ps2_byte_rx
    import ps2_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    input  logic                     timeout,
    output logic                     byte_valid_c,
    output logic                     byte_err_c,
    output logic                     frame_active_c,
    output logic                     fall_c,
    output logic [PS2_DATA_BITS-1:0] data_byte
);

    logic                 clk_meta, clk_sync, clk_hist;
    logic                 data_meta, data_sync;
    logic                 par;
    logic                 stop_ok;
    logic [BIT_CNT_W-1:0] bit_cnt;
    frame_state_t         state;

    assign fall_c         = clk_hist & ~clk_sync;
    assign stop_ok        = data_sync & (^{data_byte, par});
    assign byte_valid_c   = fall_c && (state == ST_STOP) && stop_ok;
    assign byte_err_c     = fall_c && (((state == ST_IDLE) && data_sync) ||
                                       ((state == ST_STOP) && !stop_ok));
    assign frame_active_c = (state != ST_IDLE);

    // Bus idles high, so the synchroniser resets to 1 to avoid a phantom edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_hist  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            par       <= 1'b0;
            data_byte <= '0;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            clk_hist  <= clk_sync;
            data_meta <= ps2_data;
            data_sync <= data_meta;
            if (fall_c) begin
                unique case (state)
                    ST_IDLE: begin
                        if (!data_sync) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        data_byte <= {data_sync, data_byte[PS2_DATA_BITS-1:1]};
                        bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
                        if (bit_cnt == BIT_CNT_W'(PS2_DATA_BITS - 1))
                            state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par   <= data_sync;
                        state <= ST_STOP;
                    end
                    ST_STOP: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end else if (timeout) begin
                state <= ST_IDLE;
            end
        end
    end

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver top: packet assembly, inactivity timeout, registered outputs.
module ps2_mouse_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 10000
) (
    input  logic       qzt_clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] status,
    output logic [7:0] deltaX,
    output logic [7:0] deltaY,
    output logic       tx,
    output logic       err
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic                     byte_valid_c, byte_err_c, frame_active_c, fall_c;
    logic                     busy_c, expire_c;
    logic [PS2_DATA_BITS-1:0] rx_byte;
    logic [PS2_DATA_BITS-1:0] byte0, byte1;
    logic [PKT_IDX_W-1:0]     idx;
    logic [TO_W-1:0]          to_cnt;

    ps2_byte_rx u_byte_rx (
        .clk            (qzt_clk),
        .rst_n          (rst_n),
        .ps2_clk        (ps2_clk),
        .ps2_data       (ps2_data),
        .timeout        (expire_c),
        .byte_valid_c   (byte_valid_c),
        .byte_err_c     (byte_err_c),
        .frame_active_c (frame_active_c),
        .fall_c         (fall_c),
        .data_byte      (rx_byte)
    );

    // A falling edge in the expiry cycle wins: the edge is processed instead.
    assign busy_c   = frame_active_c || (idx != '0);
    assign expire_c = busy_c && !fall_c && (to_cnt >= TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (fall_c || !busy_c || expire_c) begin
            to_cnt <= '0;
        end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            status <= '0;
            deltaX <= '0;
            deltaY <= '0;
            tx     <= 1'b0;
            err    <= 1'b0;
            byte0  <= '0;
            byte1  <= '0;
            idx    <= '0;
        end else begin
            tx  <= 1'b0;
            err <= 1'b0;
            if (byte_err_c) begin
                err <= 1'b1;
                idx <= '0;
            end else if (byte_valid_c) begin
                unique case (idx)
                    PKT_IDX_W'(0): begin
                        if (rx_byte[STAT_ALIGN_BIT]) begin
                            byte0 <= rx_byte;
                            idx   <= PKT_IDX_W'(1);
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    PKT_IDX_W'(1): begin
                        byte1 <= rx_byte;
                        idx   <= PKT_IDX_W'(2);
                    end
                    PKT_IDX_W'(2): begin
                        status <= byte0;
                        deltaX <= byte1;
                        deltaY <= rx_byte;
                        tx     <= 1'b1;
                        idx    <= '0;
                    end
                    default: idx <= '0;
                endcase
            end else if (expire_c) begin
                err <= 1'b1;
                idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Bench for ps2_mouse_rx: table-driven packets, scoreboarded tx, timeout/reset sequences.
module tb_ps2_mouse_rx;
    import ps2_pkg::*;

    localparam int unsigned TO   = 200;
    localparam int unsigned HALF = 20;

    logic       qzt_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] status, deltaX, deltaY;
    logic       tx, err;

    int checks = 0, passed = 0;
    int tx_cnt = 0, err_cnt = 0, overlap = 0, long_tx = 0;
    logic tx_d = 1'b0;
    logic [23:0] sb[$];

    typedef struct {
        logic [3:0][7:0] b;
        int              n;
        logic [3:0]      badpar;
        int              exp_tx;
        int              exp_err;
        logic [23:0]     exp_out;
    } vec_t;

    vec_t vecs[5];

    ps2_mouse_rx #(.TIMEOUT_CYC(TO)) u_dut (
        .qzt_clk  (qzt_clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .status   (status),
        .deltaX   (deltaX),
        .deltaY   (deltaY),
        .tx       (tx),
        .err      (err)
    );

    always #5 qzt_clk = ~qzt_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3, input int n,
                                input logic [3:0] bp, input int etx, eerr,
                                input logic [23:0] eo);
        vec_t v;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
        v.n = n; v.badpar = bp; v.exp_tx = etx; v.exp_err = eerr; v.exp_out = eo;
        return v;
    endfunction

    // Pulse counting and scoreboard pop, sampled away from the active edge.
    always @(negedge qzt_clk) begin
        if (tx && err) overlap++;
        if (tx && tx_d) long_tx++;
        tx_d = tx;
        if (err) err_cnt++;
        if (tx) begin
            tx_cnt++;
            check("tx_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) check("pkt", 32'({status, deltaX, deltaY}), 32'(sb.pop_front()));
        end
    end

    task automatic ps2_bit(input logic d);
        ps2_data = d;
        repeat (HALF) @(posedge qzt_clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge qzt_clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
        logic [PS2_FRAME_BITS-1:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(posedge qzt_clk);
    endtask

    task automatic send_pkt(input logic [7:0] b0, b1, b2);
        sb.push_back({b0, b1, b2});
        send_frame(b0, 1'b0, 11);
        send_frame(b1, 1'b0, 11);
        send_frame(b2, 1'b0, 11);
        repeat (10) @(posedge qzt_clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0, t0;
        vecs[0] = mk(8'h08, 8'h05, 8'hFB, 8'h00, 3, 4'b0000, 1, 0, 24'h0805FB);
        vecs[1] = mk(8'h08, 8'h05, 8'hFB, 8'h00, 3, 4'b0100, 0, 1, 24'h0805FB);
        vecs[2] = mk(8'h09, 8'hFF, 8'h01, 8'h00, 3, 4'b0000, 1, 0, 24'h09FF01);
        vecs[3] = mk(8'h00, 8'h18, 8'h10, 8'h20, 4, 4'b0000, 1, 1, 24'h181020);
        vecs[4] = mk(8'hF8, 8'h00, 8'h80, 8'h00, 3, 4'b0000, 1, 0, 24'hF80080);

        repeat (3) @(posedge qzt_clk);
        #1;
        check("reset_outputs", 32'({status, deltaX, deltaY, tx, err}), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(posedge qzt_clk);
        #1;
        check("post_reset_outputs", 32'({status, deltaX, deltaY, tx, err}), 32'd0);

        for (int i = 0; i < 5; i++) begin
            e0 = err_cnt; t0 = tx_cnt;
            if (vecs[i].exp_tx != 0) sb.push_back(vecs[i].exp_out);
            for (int k = 0; k < vecs[i].n; k++) send_frame(vecs[i].b[k], vecs[i].badpar[k], 11);
            repeat (10) @(posedge qzt_clk);
            #1;
            check($sformatf("vec%0d_tx", i), 32'(tx_cnt - t0), 32'(vecs[i].exp_tx));
            check($sformatf("vec%0d_err", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_out", i), 32'({status, deltaX, deltaY}), 32'(vecs[i].exp_out));
            check($sformatf("vec%0d_sb", i), 32'(sb.size()), 32'd0);
        end

        // Partial frame then idle bus: one timeout error, then clean decode.
        e0 = err_cnt; t0 = tx_cnt;
        send_frame(8'h0F, 1'b0, 5);
        repeat (TO + 5) @(posedge qzt_clk);
        #1;
        check("to_frame_err", 32'(err_cnt - e0), 32'd1);
        check("to_frame_idle", 32'(u_dut.u_byte_rx.state == ST_IDLE), 32'd1);
        check("to_frame_tx", 32'(tx_cnt - t0), 32'd0);
        send_pkt(8'h0C, 8'h11, 8'h22);
        check("to_frame_next_tx", 32'(tx_cnt - t0), 32'd1);
        check("to_frame_next_out", 32'({status, deltaX, deltaY}), 32'h0C1122);

        // Two bytes then timeout: index resets, no mixing with the next packet.
        e0 = err_cnt; t0 = tx_cnt;
        send_frame(8'h08, 1'b0, 11);
        send_frame(8'h01, 1'b0, 11);
        repeat (TO + 5) @(posedge qzt_clk);
        #1;
        check("to_pkt_err", 32'(err_cnt - e0), 32'd1);
        check("to_pkt_idx", 32'(u_dut.idx), 32'd0);
        send_pkt(8'h0A, 8'h02, 8'h03);
        check("to_pkt_tx", 32'(tx_cnt - t0), 32'd1);
        check("to_pkt_err_after", 32'(err_cnt - e0), 32'd1);
        check("to_pkt_out", 32'({status, deltaX, deltaY}), 32'h0A0203);

        // Asynchronous reset in the middle of byte 1.
        send_frame(8'h08, 1'b0, 11);
        send_frame(8'h05, 1'b0, 5);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", 32'({status, deltaX, deltaY, tx, err}), 32'd0);
        repeat (5) @(posedge qzt_clk);
        rst_n = 1'b1;
        repeat (5) @(posedge qzt_clk);
        e0 = err_cnt; t0 = tx_cnt;
        send_pkt(8'h28, 8'h80, 8'h7F);
        check("rst_pkt_tx", 32'(tx_cnt - t0), 32'd1);
        check("rst_pkt_err", 32'(err_cnt - e0), 32'd0);
        check("rst_pkt_out", 32'({status, deltaX, deltaY}), 32'h28807F);

        check("tx_err_overlap", 32'(overlap), 32'd0);
        check("tx_width", 32'(long_tx), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
